// File: rtl/map_pkg.sv
// rtl/map_pkg.sv - shared encodings for the map table writer
// Holds request op codes, response status codes and the writer FSM states.
package map_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_DELETE = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_UPDATED = 2'b01,
        ST_FULL    = 2'b10,
        ST_MISS    = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_CLR  = 2'b10,
        S_RESP = 2'b11
    } state_t;

endpackage

// File: rtl/map_table_writer_if.sv
// rtl/map_table_writer_if.sv - request/response handshake bundle of the map table writer
// Request side: req_valid/req_ready, req_op, req_key, req_data.
// Response side: resp_valid/resp_ready, resp_status, resp_idx.
// master = requester (bench / control path), slave = map_table_writer.
interface map_table_writer_if #(
    parameter int KEY_LEN  = 4,
    parameter int DATA_LEN = 8,
    parameter int IDX_W    = 2
);
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [KEY_LEN-1:0]  req_key;
    logic [DATA_LEN-1:0] req_data;
    logic                resp_valid;
    logic                resp_ready;
    logic [1:0]          resp_status;
    logic [IDX_W-1:0]    resp_idx;

    modport master (
        output req_valid, req_op, req_key, req_data, resp_ready,
        input  req_ready, resp_valid, resp_status, resp_idx
    );

    modport slave (
        input  req_valid, req_op, req_key, req_data, resp_ready,
        output req_ready, resp_valid, resp_status, resp_idx
    );
endinterface

// File: rtl/map_prio_enc.sv
// rtl/map_prio_enc.sv - lowest-set-bit priority encoder
// vec   : N-bit request vector
// idx   : index of the lowest set bit (0 when none set)
// found : at least one bit of vec is set
module map_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/map_table_writer.sv
// rtl/map_table_writer.sv - writer side of the packed key/data lookup table
// clk, rst   : clock, asynchronous active-high reset
// bus        : request (WRITE/DELETE/CLEAR) and status response handshakes
// lut        : packed table, slot n = {key, data} or zero when invalid
// valid_mask : occupancy per entry
// count      : number of occupied entries
module map_table_writer
    import map_pkg::*;
#(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 4,
    parameter int DATA_LEN = 8,
    parameter int IDX_W    = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    map_table_writer_if.slave                    bus,
    output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic [NR_KEY-1:0]                    valid_mask,
    output logic [IDX_W:0]                       count
);
    localparam int SLOT_W = KEY_LEN + DATA_LEN;

    state_t              state, state_nx;
    op_t                 op_q;
    logic [KEY_LEN-1:0]  rkey_q;
    logic [DATA_LEN-1:0] rdata_q;
    logic [IDX_W-1:0]    clr_cnt;
    logic [1:0]          status_q;
    logic [IDX_W-1:0]    idx_q;

    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [NR_KEY-1:0]   valid_q;

    logic [NR_KEY-1:0]   match_vec;
    logic [IDX_W-1:0]    match_idx, free_idx;
    logic                match_found, free_found;
    logic                accept, clr_last;

    assign bus.req_ready   = (state == S_IDLE) && !rst;
    assign bus.resp_valid  = (state == S_RESP);
    assign bus.resp_status = status_q;
    assign bus.resp_idx    = idx_q;
    assign accept          = bus.req_valid && bus.req_ready;
    assign clr_last        = (clr_cnt == IDX_W'(NR_KEY - 1));

    always_comb begin
        for (int n = 0; n < NR_KEY; n++) begin
            match_vec[n] = valid_q[n] && (key_q[n] == rkey_q);
        end
    end

    map_prio_enc #(.N(NR_KEY), .IDX_W(IDX_W)) u_match_enc (
        .vec   (match_vec),
        .idx   (match_idx),
        .found (match_found)
    );

    map_prio_enc #(.N(NR_KEY), .IDX_W(IDX_W)) u_free_enc (
        .vec   (~valid_q),
        .idx   (free_idx),
        .found (free_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = (op_t'(bus.req_op) == OP_CLEAR) ? S_CLR : S_EXEC;
            S_EXEC: state_nx = S_RESP;
            S_CLR:  if (clr_last) state_nx = S_RESP;
            S_RESP: if (bus.resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_WRITE;
            rkey_q   <= '0;
            rdata_q  <= '0;
            clr_cnt  <= '0;
            status_q <= '0;
            idx_q    <= '0;
            valid_q  <= '0;
            for (int n = 0; n < NR_KEY; n++) begin
                key_q[n]  <= '0;
                data_q[n] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= op_t'(bus.req_op);
                        rkey_q  <= bus.req_key;
                        rdata_q <= bus.req_data;
                        clr_cnt <= '0;
                    end
                end
                S_EXEC: begin
                    status_q <= ST_MISS;
                    idx_q    <= '0;
                    case (op_q)
                        OP_WRITE: begin
                            // An existing key always wins over FULL, even with no free slot.
                            if (match_found) begin
                                data_q[match_idx] <= rdata_q;
                                status_q          <= ST_UPDATED;
                                idx_q             <= match_idx;
                            end else if (free_found) begin
                                key_q[free_idx]   <= rkey_q;
                                data_q[free_idx]  <= rdata_q;
                                valid_q[free_idx] <= 1'b1;
                                status_q          <= ST_OK;
                                idx_q             <= free_idx;
                            end else begin
                                status_q <= ST_FULL;
                            end
                        end
                        OP_DELETE: begin
                            if (match_found) begin
                                key_q[match_idx]   <= '0;
                                data_q[match_idx]  <= '0;
                                valid_q[match_idx] <= 1'b0;
                                status_q           <= ST_OK;
                                idx_q              <= match_idx;
                            end
                        end
                        default: ;
                    endcase
                end
                S_CLR: begin
                    key_q[clr_cnt]   <= '0;
                    data_q[clr_cnt]  <= '0;
                    valid_q[clr_cnt] <= 1'b0;
                    clr_cnt          <= clr_cnt + 1'b1;
                    if (clr_last) begin
                        status_q <= ST_OK;
                        idx_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Invalid slots are forced to zero so the lookup side never sees stale keys.
    for (genvar n = 0; n < NR_KEY; n++) begin : g_slot
        assign lut[SLOT_W*(n+1)-1 -: SLOT_W] = valid_q[n] ? {key_q[n], data_q[n]} : '0;
    end

    assign valid_mask = valid_q;

    always_comb begin
        count = '0;
        for (int n = 0; n < NR_KEY; n++) begin
            count = count + (IDX_W + 1)'(valid_q[n]);
        end
    end
endmodule

// File: tb/tb_map_table_writer.sv
// tb/tb_map_table_writer.sv - self-checking bench for map_table_writer
module tb_map_table_writer;
    import map_pkg::*;

    localparam int NR_KEY = 4;
    localparam int IDX_W  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] lut;
    logic [3:0]  valid_mask;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    logic [3:0] mkey   [NR_KEY];
    logic [7:0] mdata  [NR_KEY];
    bit         mvalid [NR_KEY];

    map_table_writer_if #(.KEY_LEN(4), .DATA_LEN(8), .IDX_W(IDX_W)) bus ();

    map_table_writer #(.NR_KEY(NR_KEY), .KEY_LEN(4), .DATA_LEN(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .lut        (lut),
        .valid_mask (valid_mask),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] model_lut();
        logic [47:0] v = '0;
        for (int n = 0; n < NR_KEY; n++)
            if (mvalid[n]) v[12*n +: 12] = {mkey[n], mdata[n]};
        return v;
    endfunction

    function automatic logic [3:0] model_mask();
        logic [3:0] m = '0;
        for (int n = 0; n < NR_KEY; n++) m[n] = mvalid[n];
        return m;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int n = 0; n < NR_KEY; n++) c += int'(mvalid[n]);
        return c;
    endfunction

    task automatic model_clear();
        for (int n = 0; n < NR_KEY; n++) begin
            mvalid[n] = 0;
            mkey[n]   = '0;
            mdata[n]  = '0;
        end
    endtask

    task automatic check_table(input string tag);
        check_eq({tag, "_lut"},   lut,        model_lut());
        check_eq({tag, "_mask"},  valid_mask, model_mask());
        check_eq({tag, "_count"}, count,      model_count());
    endtask

    // One full request/response transaction; hold = cycles resp_ready stays low.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] key,
                          input logic [7:0] data, input int hold);
        int hit = -1, fr = -1, cyc, lat = 1;
        logic [1:0] es = ST_MISS, ei = '0;
        for (int n = 0; n < NR_KEY; n++) begin
            if (mvalid[n] && mkey[n] == key && hit < 0) hit = n;
            if (!mvalid[n] && fr < 0) fr = n;
        end
        case (op)
            2'b00: begin
                if (hit >= 0) begin
                    es = ST_UPDATED; ei = 2'(hit); mdata[hit] = data;
                end else if (fr >= 0) begin
                    es = ST_OK; ei = 2'(fr);
                    mvalid[fr] = 1; mkey[fr] = key; mdata[fr] = data;
                end else begin
                    es = ST_FULL;
                end
            end
            2'b01: begin
                if (hit >= 0) begin
                    es = ST_OK; ei = 2'(hit);
                    mvalid[hit] = 0; mkey[hit] = '0; mdata[hit] = '0;
                end
            end
            2'b10: begin
                es = ST_OK; lat = NR_KEY; model_clear();
            end
            default: ;
        endcase

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_key    = key;
        bus.req_data   = data;
        bus.resp_ready = (hold == 0);
        cyc = 0;
        while (!bus.req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_accept"}, cyc < 50, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_key   = 4'($urandom);
        bus.req_data  = 8'($urandom);
        cyc = 0;
        while (!bus.resp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, "_latency"}, cyc, lat);
        check_eq({tag, "_status"}, bus.resp_status, es);
        check_eq({tag, "_idx"}, bus.resp_idx, ei);
        check_table(tag);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_valid"}, bus.resp_valid, 1);
            check_eq({tag, "_hold_status"}, bus.resp_status, es);
            check_eq({tag, "_hold_ready"}, bus.req_ready, 0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_done"}, {bus.resp_valid, bus.req_ready}, 2'b01);
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        model_clear();
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_key    = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_lut", lut, 0);
        check_eq("rst_mask", valid_mask, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_req_ready", bus.req_ready, 1);
        check_eq("rst_resp_valid", bus.resp_valid, 0);

        run_op("w3", 2'b00, 4'd3, 8'hA5, 0);
        check_eq("w3_slot0", lut[11:0], 12'h3A5);
        run_op("w3_upd", 2'b00, 4'd3, 8'h5A, 0);
        check_eq("w3_upd_slot0", lut[11:0], 12'h35A);

        run_op("clr0", 2'b10, 4'd0, 8'd0, 0);
        for (int k = 1; k <= 4; k++) run_op("fill", 2'b00, 4'(k), 8'($urandom), 0);
        check_eq("fill_count", count, 4);
        run_op("w7_full", 2'b00, 4'd7, 8'h77, 0);
        run_op("w2_upd", 2'b00, 4'd2, 8'h11, 0);
        run_op("d2", 2'b01, 4'd2, 8'h00, 0);
        check_eq("d2_mask", valid_mask, 4'b1101);
        run_op("d2_miss", 2'b01, 4'd2, 8'h00, 0);
        run_op("w9", 2'b00, 4'd9, 8'h99, 0);

        run_op("clr_hold", 2'b10, 4'd0, 8'd0, 5);

        for (int k = 0; k < 4; k++) run_op("refill", 2'b00, 4'(k + 8), 8'($urandom), 0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b10;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("clr_partial_mask", valid_mask, 4'b1100);
        rst = 1'b1;
        #1;
        check_eq("midrst_lut", lut, 0);
        check_eq("midrst_mask", valid_mask, 0);
        check_eq("midrst_count", count, 0);
        check_eq("midrst_resp_valid", bus.resp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        check_eq("midrst_idle", bus.req_ready, 1);

        run_op("w0key", 2'b00, 4'd0, 8'h42, 0);
        run_op("rsvd", 2'b11, 4'd0, 8'hFF, 0);

        for (int k = 0; k < 60; k++) begin
            logic [1:0] op;
            int r = $urandom_range(0, 9);
            op = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b11 : 2'b10;
            run_op("rnd", op, 4'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
